fft_radix2_unload: RTL and testbench



---
 rtl/fft_radix2_unload.sv | 159 +++++++++++++++
 tb/tb_fft_radix2_unload.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_unload.sv
// -----------------------------------------------------------------------------
// fft_radix2_unload
//
// Purpose:
//   Consumer end of the 16-point radix-2 FFT parallel result bus. Takes one
//   complete 16-sample complex frame (flattened real/imag buses) in a single
//   valid/ready transfer. It then presents that frame one sample per beat on a
//   serial valid/ready stream for downstream logic such as a UART, a DMA engine
//   or a magnitude calculator.
//
// Configuration macro:
//   FFT_UNLOAD_BITREV_EN
//     Defined   : the buffer is read at bitrev4(cnt). The FFT's bit-reversed
//                 output order therefore comes out in natural bin order.
//     Undefined : the buffer is read at cnt. Samples pass through in capture
//                 order, and no reorder logic is built.
//   Handshake, timing and latency are identical in both builds.
//
// Parameters:
//   WIDTH  bits per real/imag component (two's complement, copied bit-exact)
//   N      frame length; only 16 is supported (the index is 4 bits wide)
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   1         frame on in_real/in_imag is valid
//   in_ready   out  1         block can capture a frame this cycle
//   in_real    in   WIDTH*16  frame real parts, sample j at [j*WIDTH +: WIDTH]
//   in_imag    in   WIDTH*16  frame imag parts, same packing
//   out_valid  out  1         out_* holds a valid sample
//   out_ready  in   1         downstream accepts the sample this cycle
//   out_real   out  WIDTH     sample real part
//   out_imag   out  WIDTH     sample imag part
//   out_index  out  4         frequency bin index of the presented sample
//   out_last   out  1         high with out_valid on the 16th sample of a frame
//   busy       out  1         high while streaming (state STREAM)
//
// Handshake rules (both interfaces):
//   A transfer happens on a rising edge where valid and ready are both high.
//   While valid is high and ready is low, the producer holds its data stable.
//   in_ready depends combinationally on out_ready. This lets a new frame load
//   on the same edge that the last sample of the current frame leaves, so the
//   output stream has no bubble between frames.
// -----------------------------------------------------------------------------
module fft_radix2_unload #(
  parameter int WIDTH = 16,
  parameter int N     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH*16-1:0] in_real,
  input  logic [WIDTH*16-1:0] in_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_real,
  output logic [WIDTH-1:0]    out_imag,
  output logic [3:0]          out_index,
  output logic                out_last,
  output logic                busy
);

  // The 4-bit sample counter and the bit-reversal both assume 16 samples.
  generate
    if (N != 16) begin : g_bad_frame_len
      $error("fft_radix2_unload: N must be 16");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] re_q [16];
  logic [WIDTH-1:0] im_q [16];

  logic             last_beat;
  logic             load;
  logic [3:0]       rd_idx;

  assign last_beat = (cnt_q == 4'd15);

  // A frame can be taken when the block is idle. It can also be taken when
  // the final sample of the current frame is leaving on this edge.
  assign in_ready = (state_q == ST_IDLE) |
                    ((state_q == ST_STREAM) & last_beat & out_ready);

  assign load = in_valid & in_ready;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      // Takes priority over the end-of-frame return to IDLE. A frame loaded
      // on the last beat continues streaming from sample 0.
      state_d = ST_STREAM;
      cnt_d   = 4'd0;
    end else if ((state_q == ST_STREAM) && out_ready) begin
      cnt_d = cnt_q + 4'd1;  // wraps 15 -> 0
      if (last_beat) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        for (int i = 0; i < 16; i++) begin
          re_q[i] <= in_real[i*WIDTH +: WIDTH];
          im_q[i] <= in_imag[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef FFT_UNLOAD_BITREV_EN
  // The FFT delivers bin k at position bitrev4(k). Reading through the
  // reversed counter presents bins in natural order.
  assign rd_idx = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};
`else
  assign rd_idx = cnt_q;
`endif

  // Outputs decode only registered state, counter and buffer. They are
  // therefore stable through any out_ready stall. In IDLE they are forced
  // to zero.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_index = 4'd0;
    out_real  = '0;
    out_imag  = '0;
    if (state_q == ST_STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = last_beat;
      out_index = cnt_q;
      out_real  = re_q[rd_idx];
      out_imag  = im_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_fft_radix2_unload.sv
// -----------------------------------------------------------------------------
// tb_fft_radix2_unload
//
// Directed bench for fft_radix2_unload. Inputs are driven 1 time unit after
// the rising edge, and outputs are sampled on the falling edge.
//
// A scoreboard queue holds, in order, every sample the DUT must still emit.
// Each entry is {last, index, imag, real}, expanded from each captured frame.
// A falling-edge monitor compares the presented sample against the head of
// the queue whenever out_valid is high. It pops the entry only when out_ready
// is high. Stalled beats must therefore stay equal to the head, and extra
// beats find the queue empty.
//
// The expected order follows FFT_UNLOAD_BITREV_EN in the same way as the DUT
// build.
// -----------------------------------------------------------------------------
module tb_fft_radix2_unload;

  localparam int W    = 16;
  localparam int SB_W = 2*W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid  = 1'b1;
  logic            in_ready;
  logic [16*W-1:0] in_real   = '0;
  logic [16*W-1:0] in_imag   = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_real;
  logic [W-1:0]    out_imag;
  logic [3:0]      out_index;
  logic            out_last;
  logic            busy;

  fft_radix2_unload #(.WIDTH(W), .N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [SB_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [3:0] sel(input logic [3:0] k);
`ifdef FFT_UNLOAD_BITREV_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  function automatic logic [W-1:0] comp(input logic [16*W-1:0] bus, input logic [3:0] s);
    return bus[s*W +: W];
  endfunction

  // Sample j = base + j*step (mod 2^W).
  function automatic logic [16*W-1:0] mk(input logic [W-1:0] base, input logic [W-1:0] step);
    logic [16*W-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[j*W +: W] = base + W'(j) * step;
    return r;
  endfunction

  task automatic push_frame(input logic [16*W-1:0] re, input logic [16*W-1:0] im);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      exp_q.push_back({(kk == 4'd15), kk, comp(im, sel(kk)), comp(re, sel(kk))});
    end
  endtask

  // ---------------- driver tasks ----------------
  // The caller is between edges. The task returns 1 time unit after the
  // capture edge, which is the first cycle of beat 0.
  task automatic send_frame(input logic [16*W-1:0] re, input logic [16*W-1:0] im);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_frame(re, im);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", got, 1'b1);
  endtask

  // Waits until every expected sample has been consumed. Returns 1 time
  // unit after a rising edge.
  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_eq_valid", busy, out_valid);
      if (out_valid) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra_beat observed=idx%0h expected=no_beat", out_index);
        end
        if (exp_q.size() != 0) begin
          chk("sb_sample", {out_last, out_index, out_imag, out_real}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  // Watchdog: the run must always end, even if the stimulus hangs.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  logic [16*W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im, e_re, e_im;
  int pops0;
  bit cap;

  initial begin
    a_re = mk(16'h0000, 16'h0001);  // j
    a_im = mk(16'h0000, 16'hFFFF);  // -j
    b_re = mk(16'h8000, 16'h0101);
    b_im = mk(16'h7FFF, 16'hFFFD);
    c_re = mk(16'h1234, 16'h0011);
    c_im = mk(16'hF000, 16'h0100);
    d_re = mk(16'h00AA, 16'h0002);
    d_im = mk(16'h5555, 16'h0003);
    e_re = mk(16'hFFF0, 16'h0001);
    e_im = mk(16'h0001, 16'h0007);

    // T1: reset held for two edges with in_valid high.
    in_real = a_re;
    in_imag = a_im;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t1_in_ready",  in_ready,  1'b1);
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_busy",      busy,      1'b0);
    chk("t1_out_last",  out_last,  1'b0);
    chk("t1_out_index", out_index, 4'd0);
    chk("t1_out_real",  out_real,  16'h0);
    chk("t1_out_imag",  out_imag,  16'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_capture", out_valid, 1'b0);

    // T2 / T6: one frame with out_ready always high.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(a_re, a_im);
    @(negedge clk);
    chk("t2_b0_valid", out_valid, 1'b1);
    chk("t2_b0_busy",  busy,      1'b1);
    chk("t2_b0_index", out_index, 4'd0);
    chk("t2_b0_real",  out_real,  16'h0000);
    chk("t2_b0_imag",  out_imag,  16'h0000);
    chk("t2_b0_last",  out_last,  1'b0);
    chk("t2_b0_inrdy", in_ready,  1'b0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t2_b1_index", out_index, 4'd1);
`ifdef FFT_UNLOAD_BITREV_EN
        chk("t2_b1_real", out_real, 16'h0008);
        chk("t2_b1_imag", out_imag, 16'hFFF8);
`else
        chk("t2_b1_real", out_real, 16'h0001);
        chk("t2_b1_imag", out_imag, 16'hFFFF);
`endif
        chk("t2_b1_last", out_last, 1'b0);
      end
      if (k == 15) begin
        chk("t2_b15_index", out_index, 4'd15);
        chk("t2_b15_real",  out_real,  16'h000F);
        chk("t2_b15_imag",  out_imag,  16'hFFF1);
        chk("t2_b15_last",  out_last,  1'b1);
        chk("t2_b15_inrdy", in_ready,  1'b1);
      end
    end
    @(negedge clk);
    chk("t2_idle_valid", out_valid, 1'b0);
    chk("t2_idle_busy",  busy,      1'b0);
    chk("t2_idle_last",  out_last,  1'b0);
    chk("t2_idle_index", out_index, 4'd0);
    chk("t2_idle_real",  out_real,  16'h0);
    chk("t2_idle_imag",  out_imag,  16'h0);
    chk("t2_idle_inrdy", in_ready,  1'b1);
    chk("t2_sb_empty",   exp_q.size(), 0);

    // T3: backpressure while beat 3 is presented.
    @(posedge clk);
    #1;
    pops0 = pops;
    send_frame(c_re, c_im);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_index", out_index, 4'd3);
      chk("t3_hold_real",  out_real,  comp(c_re, sel(4'd3)));
      chk("t3_hold_imag",  out_imag,  comp(c_im, sel(4'd3)));
      @(posedge clk);
      #1;
    end
    drain();
    chk("t3_beat_count", pops - pops0, 16);
    @(negedge clk);
    chk("t3_idle_valid", out_valid, 1'b0);

    // T4: frame B offered during frame A, captured on A's last beat.
    @(posedge clk);
    #1;
    send_frame(a_re, a_im);
    in_valid = 1'b1;
    in_real  = b_re;
    in_imag  = b_im;
    cap      = 1'b0;
    for (int c = 0; c < 20 && !cap; c++) begin
      @(negedge clk);
      chk("t4_no_drop", out_valid, 1'b1);
      if (in_ready) begin
        chk("t4_cap_index", out_index, 4'd15);
        chk("t4_cap_last",  out_last,  1'b1);
        push_frame(b_re, b_im);
        cap = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("t4_captured", cap, 1'b1);
    @(negedge clk);
    chk("t4_b0_valid", out_valid, 1'b1);
    chk("t4_b0_index", out_index, 4'd0);
    chk("t4_b0_last",  out_last,  1'b0);
    chk("t4_b0_real",  out_real,  comp(b_re, sel(4'd0)));
    chk("t4_b0_imag",  out_imag,  comp(b_im, sel(4'd0)));
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    chk("t4_idle_valid", out_valid, 1'b0);

    // T5: reset asserted while beat 6 is presented.
    @(posedge clk);
    #1;
    send_frame(d_re, d_im);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_b6_index", out_index, 4'd6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_inrdy", in_ready,  1'b1);
    chk("t5_rst_busy",  busy,      1'b0);
    chk("t5_rst_index", out_index, 4'd0);
    chk("t5_rst_real",  out_real,  16'h0);
    @(posedge clk);
    #1;
    send_frame(e_re, e_im);
    @(negedge clk);
    chk("t5_next_index", out_index, 4'd0);
    chk("t5_next_real",  out_real,  comp(e_re, sel(4'd0)));
    chk("t5_next_imag",  out_imag,  comp(e_im, sel(4'd0)));
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    chk("t5_end_valid", out_valid, 1'b0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
